// File: rtl/rf_writeback_queue_if.sv
// Request, register-file write and forwarding signals of the writeback queue.
// The slave side is the queue; the master side drives requests and read addresses.
interface rf_writeback_queue_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int PTR_WIDTH  = 2
);
  logic                  iAluValid;
  logic [ADDR_WIDTH-1:0] iAluAddr;
  logic [DATA_WIDTH-1:0] iAluData;
  logic                  oAluReady;
  logic                  iLdValid;
  logic [ADDR_WIDTH-1:0] iLdAddr;
  logic [DATA_WIDTH-1:0] iLdData;
  logic                  oLdReady;
  logic [ADDR_WIDTH-1:0] oAddrWrite;
  logic [DATA_WIDTH-1:0] oDataWrite;
  logic                  oEnWrite;
  logic [ADDR_WIDTH-1:0] iAddrRead0;
  logic [ADDR_WIDTH-1:0] iAddrRead1;
  logic                  oFwdHit0;
  logic [DATA_WIDTH-1:0] oFwdData0;
  logic                  oFwdHit1;
  logic [DATA_WIDTH-1:0] oFwdData1;
  logic [PTR_WIDTH:0]    oCount;
  logic                  oFull;
  logic                  oEmpty;

  modport slave (
    input  iAluValid, iAluAddr, iAluData, iLdValid, iLdAddr, iLdData, iAddrRead0, iAddrRead1,
    output oAluReady, oLdReady, oAddrWrite, oDataWrite, oEnWrite,
           oFwdHit0, oFwdData0, oFwdHit1, oFwdData1, oCount, oFull, oEmpty
  );

  modport master (
    output iAluValid, iAluAddr, iAluData, iLdValid, iLdAddr, iLdData, iAddrRead0, iAddrRead1,
    input  oAluReady, oLdReady, oAddrWrite, oDataWrite, oEnWrite,
           oFwdHit0, oFwdData0, oFwdHit1, oFwdData1, oCount, oFull, oEmpty
  );
endinterface

// File: rtl/rf_writeback_queue.sv
// In-order writeback queue in front of the register file write port: two producers
// in, one write per iClk period out, with forwarding of pending writes.
module rf_writeback_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 4,
  parameter int PTR_WIDTH  = 2
) (
  input  logic iClkX2,
  input  logic iRst_n,
  input  logic iClk,
  rf_writeback_queue_if.slave bus
);
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  typedef struct packed {
    logic                  hit;
    logic [DATA_WIDTH-1:0] data;
  } fwd_t;

  localparam logic [PTR_WIDTH:0] DEPTH_C = (PTR_WIDTH+1)'(DEPTH);

  entry_t               rMem [DEPTH];
  logic [PTR_WIDTH-1:0] rHead, rTail;
  logic [PTR_WIDTH:0]   rCount;
  logic                 rPhase;
  entry_t               rOut;
  logic                 rEn;

  logic [PTR_WIDTH:0]   free, nPush;
  logic                 ldReady, aluReady, ldPush, aluPush, pop;
  logic [PTR_WIDTH-1:0] aluIdx;
  fwd_t                 fwd0, fwd1;

  assign free     = DEPTH_C - rCount;
  assign ldReady  = iRst_n && (free != '0);
  // A single free slot goes to the load, which has priority.
  assign aluReady = iRst_n && ((free >= (PTR_WIDTH+1)'(2)) ||
                               (free == (PTR_WIDTH+1)'(1) && !bus.iLdValid));
  assign ldPush   = bus.iLdValid  && ldReady  && (bus.iLdAddr  != '0);
  assign aluPush  = bus.iAluValid && aluReady && (bus.iAluAddr != '0);
  assign nPush    = (PTR_WIDTH+1)'(ldPush) + (PTR_WIDTH+1)'(aluPush);
  assign aluIdx   = rTail + PTR_WIDTH'(ldPush);
  // rPhase low marks the start of the register file write phase.
  assign pop      = !rPhase && (rCount != '0);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge iClkX2) begin
    rPhase <= iClk;
    if (!iRst_n) begin
      rHead  <= '0;
      rTail  <= '0;
      rCount <= '0;
      rEn    <= 1'b0;
      rOut   <= '0;
    end else begin
      if (!rPhase) begin
        if (rCount != '0) begin
          rOut  <= rMem[rHead];
          rEn   <= 1'b1;
          rHead <= rHead + PTR_WIDTH'(1);
        end else begin
          rEn <= 1'b0;
        end
      end
      rTail  <= rTail + nPush[PTR_WIDTH-1:0];
      rCount <= rCount + nPush - (PTR_WIDTH+1)'(pop);
    end
  end

  // NOTE: storage has no reset; entries are only visible through rCount, which is reset.
  always_ff @(posedge iClkX2) begin
    if (ldPush)  rMem[rTail]  <= '{addr: bus.iLdAddr,  data: bus.iLdData};
    if (aluPush) rMem[aluIdx] <= '{addr: bus.iAluAddr, data: bus.iAluData};
  end

  // Walk from the output register (oldest) to the tail so the youngest match wins.
  function automatic fwd_t lookup(input logic [ADDR_WIDTH-1:0] addr);
    fwd_t                 res;
    logic [PTR_WIDTH-1:0] idx;
    res = '0;
    if (addr != '0) begin
      if (rEn && rOut.addr == addr) res = '{hit: 1'b1, data: rOut.data};
      for (int i = 0; i < DEPTH; i++) begin
        idx = rHead + PTR_WIDTH'(i);
        if ((PTR_WIDTH+1)'(i) < rCount && rMem[idx].addr == addr)
          res = '{hit: 1'b1, data: rMem[idx].data};
      end
    end
    return res;
  endfunction

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    fwd0 = '0;
    fwd1 = '0;
    fwd0 = lookup(bus.iAddrRead0);
    fwd1 = lookup(bus.iAddrRead1);
  end

  assign bus.oLdReady   = ldReady;
  assign bus.oAluReady  = aluReady;
  assign bus.oAddrWrite = rOut.addr;
  assign bus.oDataWrite = rOut.data;
  assign bus.oEnWrite   = rEn;
  assign bus.oFwdHit0   = fwd0.hit;
  assign bus.oFwdData0  = fwd0.data;
  assign bus.oFwdHit1   = fwd1.hit;
  assign bus.oFwdData1  = fwd1.data;
  assign bus.oCount     = rCount;
  assign bus.oFull      = (rCount == DEPTH_C);
  assign bus.oEmpty     = (rCount == '0);
endmodule

// File: doc/rf_writeback_queue.md
Name: rf_writeback_queue

Overview:
- Writeback stage directly upstream of the register file write port.
- Accepts register write requests from two producers, the ALU and the load unit, and buffers them in a small in-order queue.
- Issues at most one write per iClk period on oAddrWrite/oDataWrite/oEnWrite, held stable across the register file's write (iClk-high) phase.
- Provides forwarding lookup of pending writes for both read addresses so decode can bypass data not yet in the register file.

Parameters:
DATA_WIDTH, 32, register data width
ADDR_WIDTH, 5, register address width
DEPTH, 4, queue entries; power of two, >= 2
PTR_WIDTH, 2, log2(DEPTH)

Ports:
iClkX2  input  1  double-rate clock; all state updates on posedge
iRst_n  input  1  synchronous active-low reset, sampled on posedge iClkX2
iClk  input  1  base clock, used only as phase reference
iAluValid  input  1  ALU write request
iAluAddr  input  ADDR_WIDTH  ALU destination register
iAluData  input  DATA_WIDTH  ALU result
oAluReady  output  1  ALU request accepted this edge
iLdValid  input  1  load write request
iLdAddr  input  ADDR_WIDTH  load destination register
iLdData  input  DATA_WIDTH  load data
oLdReady  output  1  load request accepted this edge
oAddrWrite  output  ADDR_WIDTH  register file write address
oDataWrite  output  DATA_WIDTH  register file write data
oEnWrite  output  1  register file write enable
iAddrRead0  input  ADDR_WIDTH  forwarding lookup address 0
iAddrRead1  input  ADDR_WIDTH  forwarding lookup address 1
oFwdHit0  output  1  pending write matches iAddrRead0
oFwdData0  output  DATA_WIDTH  forwarded data for port 0
oFwdHit1  output  1  pending write matches iAddrRead1
oFwdData1  output  DATA_WIDTH  forwarded data for port 1
oCount  output  PTR_WIDTH+1  occupied queue entries
oFull  output  1  oCount == DEPTH
oEmpty  output  1  oCount == 0

Behaviour:
- Reset (posedge iClkX2 with iRst_n=0):
  - head, tail and count cleared; queue contents discarded, including mid-operation.
  - oEnWrite=0, oAddrWrite=0, oDataWrite=0.
  - oAluReady=oLdReady=0 while iRst_n=0.
- Phase tracking: rPhase <= iClk on every posedge iClkX2. A slot edge is a posedge iClkX2 with rPhase==0 (start of the register file write phase).
- Enqueue (any posedge iClkX2):
  - free = DEPTH - count, using pre-edge count.
  - oLdReady = (free >= 1).
  - oAluReady = (free >= 2) || (free == 1 && !iLdValid).
  - A transfer occurs when valid && ready on the same edge.
  - Load has priority. When both transfer, the load entry is written first (older), the ALU entry second.
  - Requests to address 0 are accepted but not stored: no count change, no forwarding.
- Dequeue (slot edges only):
  - If count (pre-edge) > 0: head entry moves to the output registers, oEnWrite=1, head++.
  - Otherwise oEnWrite=0 and oAddrWrite/oDataWrite are held.
  - Outputs change only on slot edges, so they are stable for the whole following iClk period.
- A pop frees its slot only after the edge. Ready never counts a same-edge pop.
- Simultaneous enqueue and pop on one edge is legal: count_next = count + pushes - pop.
- Pointers wrap modulo DEPTH. Overflow is impossible by construction; count never exceeds DEPTH.
- Latency:
  - An entry enqueued on edge E reaches the outputs at the first slot edge strictly after E, with no same-edge bypass.
  - In-order: the register file sees writes in acceptance order.
- Forwarding (combinational):
  - Search the valid queue entries plus the output register (when oEnWrite=1).
  - Youngest match wins; the output register is the oldest.
  - Address 0 never hits.
  - oFwdData* = 0 when not hit.

Test Plan:
- Reset with 2 entries queued → oCount=0, oEnWrite=0, oEmpty=1, oFwdHit0=0; iRst_n=0 forces both readies low.
- Single ALU write r3=0xDEADBEEF into empty queue → oAddrWrite=3, oDataWrite=0xDEADBEEF, oEnWrite=1 at next slot edge, held 2 iClkX2 cycles; oEnWrite=0 at the following slot edge.
- Simultaneous load r5=0x11 and ALU r6=0x22 → both accepted, oCount=2; r5 issued at the first slot edge, r6 at the second.
- Fill to DEPTH=4 with r1..r4 → oFull=1, oLdReady=0, oAluReady=0; held requests accepted on the edge after the next slot-edge pop; free==1 with both valid → only load accepted.
- Forward: queue r7=0xA then r7=0xB, iAddrRead0=7 → oFwdHit0=1, oFwdData0=0xB; iAddrRead1=0 → oFwdHit1=0.
- Write to r0 with data 0xFFFF → accepted, oCount unchanged, never appears on oEnWrite; wrap test: 10 sequential writes, all emitted in order.
